// File: rtl/pipe_data_path.sv
// pipe_data_path: three-stage (ID / EX / WB) register-file + ALU datapath.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valid        instruction issued this cycle (ID stage)
//   stall           freeze all pipeline state and suppress the RF write
//   RegWrite        issued instruction writes rd
//   ALUsrc          1: operand B = ImmOp, 0: operand B = rs2 value
//   ALUctrl         ADD SUB AND OR XOR SLT SLL SRL (000..111)
//   rs1, rs2, rd    register indices
//   ImmOp           sign-extended immediate
//   result          WB-stage ALU result
//   result_valid    WB stage holds a valid instruction
//   EQ              WB-stage flag, operand A == post-mux operand B
//   a0              combinational read of register REG_A0
//
// Operands are bypassed from EX (live ALU output) before WB (registered
// result) before the register file, so back-to-back dependent instructions
// see in-order results. The RF is written at the edge that ends WB.
module pipe_data_path #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_A0        = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     RegWrite,
    input  logic                     ALUsrc,
    input  logic [2:0]               ALUctrl,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    output logic [DATA_WIDTH-1:0]    result,
    output logic                     result_valid,
    output logic                     EQ,
    output logic [DATA_WIDTH-1:0]    a0
);
    localparam int NUM_REGS = 2**ADDRESS_WIDTH;
    localparam int SHAMT_W  = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef struct packed {
        logic                     rw;   // already gated by in_valid
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [2:0]               op;
        logic [DATA_WIDTH-1:0]    a;
        logic [DATA_WIDTH-1:0]    b;    // post-mux operand B
    } id_ex_t;

    typedef struct packed {
        logic                     rw;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    res;
        logic                     eq;
    } ex_wb_t;

    // vld_pipe[0] = EX stage valid, vld_pipe[1] = WB stage valid
    logic [1:0]                            vld_pipe_q, vld_pipe_d;
    id_ex_t                                ex_q, ex_d;
    ex_wb_t                                wb_q, wb_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   rf_q, rf_d;

    logic [DATA_WIDTH-1:0]                 alu_out;
    logic [1:0][ADDRESS_WIDTH-1:0]         rs_idx;
    logic [1:0][DATA_WIDTH-1:0]            opnd;
    logic [DATA_WIDTH-1:0]                 op_b;
    logic                                  rf_we;

    // EX-stage ALU
    always_comb begin
        alu_out = '0;
        case (ex_q.op)
            OP_ADD:  alu_out = ex_q.a + ex_q.b;
            OP_SUB:  alu_out = ex_q.a - ex_q.b;
            OP_AND:  alu_out = ex_q.a & ex_q.b;
            OP_OR:   alu_out = ex_q.a | ex_q.b;
            OP_XOR:  alu_out = ex_q.a ^ ex_q.b;
            OP_SLT:  alu_out[0] = $signed(ex_q.a) < $signed(ex_q.b);
            OP_SLL:  alu_out = ex_q.a << ex_q.b[SHAMT_W-1:0];
            OP_SRL:  alu_out = ex_q.a >> ex_q.b[SHAMT_W-1:0];
            default: alu_out = '0;
        endcase
    end

    // ID-stage operand read with bypass; index 0 short-circuits to zero so
    // a discarded write to x0 can never be forwarded.
    assign rs_idx = {rs2, rs1};

    always_comb begin
        opnd = '0;
        for (int i = 0; i < 2; i++) begin
            if (rs_idx[i] == '0)
                opnd[i] = '0;
            else if (vld_pipe_q[0] && ex_q.rw && ex_q.rd == rs_idx[i])
                opnd[i] = alu_out;
            else if (vld_pipe_q[1] && wb_q.rw && wb_q.rd == rs_idx[i])
                opnd[i] = wb_q.res;
            else
                opnd[i] = rf_q[rs_idx[i]];
        end
    end

    assign op_b = ALUsrc ? ImmOp : opnd[1];

    // Next state: stall holds everything, including the RF.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        ex_d       = ex_q;
        wb_d       = wb_q;
        rf_d       = rf_q;
        rf_we      = !stall && vld_pipe_q[1] && wb_q.rw && (wb_q.rd != '0);
        if (!stall) begin
            vld_pipe_d = {vld_pipe_q[0], in_valid};
            ex_d.rw    = in_valid & RegWrite;
            ex_d.rd    = rd;
            ex_d.op    = ALUctrl;
            ex_d.a     = opnd[0];
            ex_d.b     = op_b;
            wb_d.rw    = ex_q.rw;
            wb_d.rd    = ex_q.rd;
            wb_d.res   = alu_out;
            wb_d.eq    = (ex_q.a == ex_q.b);
        end
        if (rf_we)
            rf_d[wb_q.rd] = wb_q.res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            ex_q       <= '0;
            wb_q       <= '0;
            rf_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            ex_q       <= ex_d;
            wb_q       <= wb_d;
            rf_q       <= rf_d;
        end
    end

    assign result       = wb_q.res;
    assign result_valid = vld_pipe_q[1];
    assign EQ           = wb_q.eq;
    assign a0           = rf_q[REG_A0];

endmodule

// File: doc/pipe_data_path.md
Name: pipe_data_path

Overview:
Three-stage pipelined successor to the single-cycle register-file/ALU/immediate-select datapath. Parametrised in register count and data width, with an 8-operation ALU, EX→ID and WB→ID operand bypass, bubble insertion and global stall. Sits between the decoder/control unit and the branch logic. Exposes the registered ALU result, the EQ flag and the a0 register.

Parameters:
ADDRESS_WIDTH, 5, register index width; register file depth = 2**ADDRESS_WIDTH.
DATA_WIDTH, 32, register and ALU data width; must be a power of two, ≥8.
REG_A0, 10, register index continuously driven on a0.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  an instruction is issued this cycle (ID stage).
stall  in  1  freeze every pipeline register and suppress the register-file write.
RegWrite  in  1  issued instruction writes rd.
ALUsrc  in  1  1: operand B = ImmOp; 0: operand B = rs2 value.
ALUctrl  in  3  ALU operation, see Behaviour.
rs1  in  ADDRESS_WIDTH  source register 1.
rs2  in  ADDRESS_WIDTH  source register 2.
rd  in  ADDRESS_WIDTH  destination register.
ImmOp  in  DATA_WIDTH  sign-extended immediate.
result  out  DATA_WIDTH  WB-stage ALU result.
result_valid  out  1  WB stage holds a valid instruction.
EQ  out  1  WB-stage flag: operand A == operand B (post-mux).
a0  out  DATA_WIDTH  combinational read of register REG_A0.

Behaviour:
- Stages:
  - ID, issue cycle N: operand read plus bypass, B-mux; the result is captured into the ID/EX registers.
  - EX, N+1: ALU evaluates; the result and EQ are captured into the EX/WB registers.
  - WB, N+2: result/EQ/result_valid are visible; the register file is written on the clk edge ending N+2.
  - a0 reflects the write from N+3.
- Register file: 2**ADDRESS_WIDTH × DATA_WIDTH; async reads; one write port. Writes to index 0 are discarded and reads of index 0 return 0.
- Bypass priority for each source rs (rs ≠ 0):
  - EX stage valid, RegWrite and rd == rs → combinational ALU output.
  - Else WB stage valid, RegWrite and rd == rs → WB result.
  - Else register file.
  - The B-mux applies after bypass. EQ compares the bypassed A against the post-mux B.
- ALUctrl:
  - 000 ADD; 001 SUB; 010 AND; 011 OR; 100 XOR.
  - 101 SLT: signed, result 1 or 0, zero-extended.
  - 110 SLL, 111 SRL (logical). Shift amount = B[$clog2(DATA_WIDTH)-1:0].
  - Add/sub wrap modulo 2**DATA_WIDTH; no overflow flag.
- in_valid=0 inserts a bubble: the stage valid bit is 0, RegWrite is forced 0 in the pipeline, and its operands are don't-care.
- stall=1:
  - All stage registers, including valid bits, hold.
  - No register-file write occurs.
  - ID inputs are ignored; upstream holds the instruction.
  - result/result_valid/EQ stay stable.
  - Release resumes with no lost or duplicated write.
- Reset (async, any time, including mid-pipeline):
  - All valid bits → 0; result → 0; EQ → 0; result_valid → 0.
  - All registers → 0, so a0 → 0 immediately.
  - In-flight instructions are discarded.
  - The first issue is accepted on the first rising edge after rst_n deasserts.
- Each issue cycle produces exactly one WB cycle; throughput is one instruction per unstalled cycle.

Test Plan:
- Reset mid-flight: issue ADD x10=x0+imm 5, assert rst_n=0 during EX → result_valid=0, a0=0, no write; after release, reissue → a0=5 at N+3.
- Back-to-back EX bypass: N: x1=x0+7 (ALUsrc=1); N+1: x2=x1+x1 (ALUsrc=0) → WB of second instruction result=14; N+2: x10=x2+0 → a0=14 at N+5.
- WB bypass and priority:
  - x3=9 at N, bubble at N+1, x4=x3+1 at N+2 → result 10.
  - With x3 written at both N and N+1 (values 1 then 2), a consumer at N+2 sees 2 (EX wins).
- x0 protection: ADD x0=x0+imm 0xFFFF_FFFF, then x5=x0+0 → result 0; no bypass from rd=0.
- ALU ops at DATA_WIDTH=32:
  - SUB 3−5=0xFFFF_FFFE; SLT −1<1 → 1.
  - SLL 1<<31=0x8000_0000; SRL 0x8000_0000>>35 (amount 3) → 0x1000_0000.
  - EQ=1 for 0x5A vs imm 0x5A.
- Stall: issue x10=x0+42, hold stall=1 for 3 cycles while the instruction is in EX → result_valid stays 0, a0 stays 0. Release → result=42 two cycles later, exactly one write, a0=42.
